// File: rtl/bram_out_reader_srp.sv
// Reads a frame of bytes from the output-buffer BRAM, wrapping at DEPTH, and streams them out on AXI4-Stream.
// A 2-entry skid FIFO, fed by the 1-cycle BRAM read data, absorbs read latency and downstream stalls.
module bram_out_reader_srp #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 768
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] len,
  output logic              busy,
  output logic              done,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast
);
  // IDLE: wait for start | READ: issue reads | DRAIN: all reads issued, emptying FIFO | FIN: done pulse
  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;
  state_t state, state_nxt;

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0]     DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0]     ONE_C     = CW'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [CW-1:0]     len_clamp, len_q, issued, popped;
  logic [1:0]        fifo_count;
  logic [DATA_W-1:0] fifo_mem [2];
  logic              wr_ptr, rd_ptr;
  logic              inflight, pop, push, pop_mem, issue_ok, accept;
  logic [2:0]        occ;
  logic [DATA_W-1:0] head;

  assign len_clamp = ({1'b0, len} > DEPTH_C) ? DEPTH_C : {1'b0, len};
  assign accept    = start && (state == IDLE);

  // With the FIFO empty, the arriving BRAM word is presented directly so the first byte costs one cycle only.
  assign m_axis_tvalid = (fifo_count != 2'd0) || inflight;
  assign head          = (fifo_count == 2'd0) ? bram_dout : fifo_mem[rd_ptr];
  assign m_axis_tdata  = m_axis_tvalid ? head : '0;
  assign m_axis_tlast  = m_axis_tvalid && ((popped + ONE_C) == len_q);
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign pop_mem       = pop && (fifo_count != 2'd0);
  assign push          = inflight && !(pop && (fifo_count == 2'd0));
  assign occ           = {1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop};
  assign issue_ok      = (occ < 3'd2) && (issued < len_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len_clamp == '0) ? FIN : READ;
      READ:    if (bram_en && ((issued + ONE_C) == len_q)) state_nxt = DRAIN;
      DRAIN:   if (pop && m_axis_tlast) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state == READ) || (state == DRAIN);
    done    = (state == FIN);
    bram_en = (state == READ) && issue_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q     <= '0;
      issued    <= '0;
      popped    <= '0;
      bram_addr <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= bram_en;
      if (accept) begin
        len_q     <= len_clamp;
        bram_addr <= base_addr;
        issued    <= '0;
        popped    <= '0;
      end else begin
        if (bram_en) begin
          bram_addr <= (bram_addr == LAST_ADDR) ? '0 : bram_addr + ADDR_W'(1);
          issued    <= issued + ONE_C;
        end
        if (pop) popped <= popped + ONE_C;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_count  <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= bram_dout;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop_mem) rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop_mem};
    end
  end
endmodule

// File: tb/tb_bram_out_reader_srp.sv
// Directed bench for bram_out_reader_srp: table of frames with hand-computed results plus reset sequences.
module tb_bram_out_reader_srp;
  localparam int DEPTH = 768;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [9:0] base_addr = '0, len = '0;
  logic       busy, done, bram_en;
  logic [9:0] bram_addr;
  logic [7:0] bram_dout, m_axis_tdata;
  logic       m_axis_tvalid, m_axis_tlast;
  logic       m_axis_tready = 1'b1;
  logic [7:0] mem [DEPTH];

  int tests = 0, fails = 0;
  int g_n, g_en, g_done_cyc, g_done_cnt, g_last_data, g_first_en, g_first_vld;
  int g_err_addr, g_err_data, g_err_last, g_err_stable, g_err_occ, g_err_busy, g_err_post;

  typedef struct {
    int base; int ln; int stall_after; int stall_cyc; int extra;
    int exp_n; int exp_en; int exp_done; int exp_last; int exp_first_en; int exp_first_vld;
  } vec_t;
  vec_t vecs [6];

  bram_out_reader_srp dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) if (bram_en) bram_dout <= mem[bram_addr];

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_frame(input int base, input int ln, input int stall_after,
                           input int stall_cyc, input int exp_done, input int extra);
    int eff, rem;
    bit seen_done, prev_stall, exp_busy;
    logic [7:0] prev_data;
    eff = (ln > DEPTH) ? DEPTH : ln;
    g_n = 0; g_en = 0; g_done_cyc = -1; g_done_cnt = 0; g_last_data = -1;
    g_first_en = -1; g_first_vld = -1;
    g_err_addr = 0; g_err_data = 0; g_err_last = 0; g_err_stable = 0;
    g_err_occ = 0; g_err_busy = 0; g_err_post = 0;
    seen_done = 0; prev_stall = 0; prev_data = '0; rem = stall_cyc;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 10'(base); len = 10'(ln); m_axis_tready = 1'b1;
    for (int cyc = 0; cyc < 2 * eff + 60; cyc++) begin
      @(negedge clk);
      if (bram_en) begin
        if (g_first_en < 0) g_first_en = cyc;
        if (seen_done || bram_addr != 10'((base + g_en) % DEPTH)) g_err_addr++;
        g_en++;
      end
      if (m_axis_tvalid && g_first_vld < 0) g_first_vld = cyc;
      if (prev_stall && (!m_axis_tvalid || m_axis_tdata != prev_data)) g_err_stable++;
      if (m_axis_tvalid && m_axis_tready) begin
        if (m_axis_tdata != 8'((base + g_n) % DEPTH)) g_err_data++;
        if (m_axis_tlast != (g_n == eff - 1)) g_err_last++;
        g_last_data = int'(m_axis_tdata);
        g_n++;
      end
      if (g_en - g_n > 2) g_err_occ++;
      if (done) begin
        g_done_cnt++;
        if (!seen_done) g_done_cyc = cyc;
        seen_done = 1;
      end
      exp_busy = (cyc >= 1) && !seen_done;
      if (busy != exp_busy) g_err_busy++;
      if (seen_done && !done && (m_axis_tvalid || bram_en || busy)) g_err_post++;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      if (seen_done && cyc >= g_done_cyc + 2) break;
      @(posedge clk); #1;
      start = (extra != 0) && (cyc + 1 == 2 || cyc + 1 == exp_done);
      if (start) begin base_addr = 10'd500; len = 10'd3; end
      if (g_n >= stall_after && rem > 0) begin m_axis_tready = 1'b0; rem--; end
      else m_axis_tready = 1'b1;
    end
    start = 1'b0; m_axis_tready = 1'b1;
  endtask

  initial begin
    int dcnt;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);
    //            base  ln stall_at stall_cyc extra n  en  done last fen fvld
    vecs[0] = '{   0,    4, 0, 0, 0,   4,   4,   6,   3, 1,  2};
    vecs[1] = '{ 766,    4, 0, 0, 0,   4,   4,   6,   1, 1,  2};
    vecs[2] = '{  10,    8, 2, 5, 0,   8,   8,  15,  17, 1,  2};
    vecs[3] = '{   0,    0, 0, 0, 0,   0,   0,   1,  -1, -1, -1};
    vecs[4] = '{   0, 1000, 0, 0, 0, 768, 768, 770, 255, 1,  2};
    vecs[5] = '{  20,    6, 0, 0, 1,   6,   6,   8,  25, 1,  2};

    #22;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_bram_en", bram_en, 0);
    check("reset_bram_addr", bram_addr, 0);
    check("reset_tvalid", m_axis_tvalid, 0);
    check("reset_tlast", m_axis_tlast, 0);
    check("reset_tdata", m_axis_tdata, 0);
    @(posedge clk); #1; rst_n = 1'b1;

    foreach (vecs[k]) begin
      run_frame(vecs[k].base, vecs[k].ln, vecs[k].stall_after, vecs[k].stall_cyc,
                vecs[k].exp_done, vecs[k].extra);
      check($sformatf("v%0d_bytes", k), g_n, vecs[k].exp_n);
      check($sformatf("v%0d_reads", k), g_en, vecs[k].exp_en);
      check($sformatf("v%0d_done_cycle", k), g_done_cyc, vecs[k].exp_done);
      check($sformatf("v%0d_done_count", k), g_done_cnt, 1);
      check($sformatf("v%0d_last_byte", k), g_last_data, vecs[k].exp_last);
      check($sformatf("v%0d_first_en", k), g_first_en, vecs[k].exp_first_en);
      check($sformatf("v%0d_first_valid", k), g_first_vld, vecs[k].exp_first_vld);
      check($sformatf("v%0d_addr_errs", k), g_err_addr, 0);
      check($sformatf("v%0d_data_errs", k), g_err_data, 0);
      check($sformatf("v%0d_tlast_errs", k), g_err_last, 0);
      check($sformatf("v%0d_stable_errs", k), g_err_stable, 0);
      check($sformatf("v%0d_outstanding_errs", k), g_err_occ, 0);
      check($sformatf("v%0d_busy_errs", k), g_err_busy, 0);
      check($sformatf("v%0d_post_done_errs", k), g_err_post, 0);
    end

    // Reset in the middle of a len-8 frame, after three bytes have been delivered.
    @(posedge clk); #1;
    start = 1'b1; base_addr = 10'd0; len = 10'd8; m_axis_tready = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("midrst_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_bram_en", bram_en, 0);
    check("midrst_bram_addr", bram_addr, 0);
    check("midrst_tvalid", m_axis_tvalid, 0);
    check("midrst_tlast", m_axis_tlast, 0);
    check("midrst_tdata", m_axis_tdata, 0);
    dcnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || m_axis_tvalid || bram_en) dcnt++;
    end
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done || m_axis_tvalid || bram_en || busy) dcnt++;
    end
    check("midrst_quiet_cycles", dcnt, 0);

    run_frame(0, 2, 0, 0, 4, 0);
    check("postrst_bytes", g_n, 2);
    check("postrst_last_byte", g_last_data, 1);
    check("postrst_done_cycle", g_done_cyc, 4);
    check("postrst_done_count", g_done_cnt, 1);
    check("postrst_data_errs", g_err_data, 0);
    check("postrst_tlast_errs", g_err_last, 0);
    check("postrst_busy_errs", g_err_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
